pipe_collision_engine: RTL and testbench
========================================

PIPE_COLLISION_ENGINE -- requirements
Module: pipe_collision_engine

Interface
REQ-001 Parameter NUM_PIPES, default 3: number of pipe channels checked in parallel, 1..8.
REQ-002 Parameter X_W, default 9: pipe x-coordinate width.
REQ-003 Parameter Y_W, default 7: box and pipe y-coordinate width.
REQ-004 Parameters BOX_X 4, BOX_W 1, BOX_H 1, PIPE_W 1, GAP_H 30, SCREEN_H 120: geometry in pixels.
REQ-005 Parameter SCORE_W, default 8: score counter width.
REQ-006 CLOCK_50  in  1  system clock; all state updates on its rising edge.
REQ-007 resetn  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  level; begins a round from IDLE.
REQ-009 ack  in  1  level; acknowledges a hit and returns the block to IDLE.
REQ-010 box_y  in  Y_W  top row of the box.
REQ-011 pipe_x  in  NUM_PIPES*X_W  packed left columns; channel i occupies bits [i*X_W +: X_W].
REQ-012 pipe_y  in  NUM_PIPES*Y_W  packed gap top rows, same packing as pipe_x.
REQ-013 collided  out  1  high while in HIT.
REQ-014 hit_id  out  4  lowest channel index that caused the hit; value NUM_PIPES means ground or ceiling.
REQ-015 score  out  SCORE_W  number of pipes passed this round.
REQ-016 playing  out  1  high while in PLAY.

Function
REQ-017 Overlap for channel i SHALL mean the x-span [BOX_X, BOX_X+BOX_W-1] intersects [pipe_x, pipe_x+PIPE_W-1] and the y-span [box_y, box_y+BOX_H-1] is not fully inside [pipe_y, pipe_y+GAP_H].
REQ-018 All geometry sums SHALL be computed at width+2 bits so that no sum wraps; a gap extending past SCREEN_H-1 is treated as clipped.
REQ-019 The FSM SHALL have three states, IDLE, PLAY and HIT, with the following transitions.
  IDLE->PLAY: on start; score is cleared on the same edge.
  PLAY->HIT: when any overlap is sampled.
  HIT->IDLE: on ack.
  All other conditions hold the current state.
REQ-020 Overlaps SHALL be ignored in IDLE and HIT, including the cycle in which start is first seen.
REQ-021 collided and hit_id SHALL update on the first edge after the overlapping inputs are sampled (1-cycle latency).
REQ-022 When several channels overlap in the same cycle, hit_id SHALL be the lowest such index.
REQ-023 hit_id SHALL hold its value through HIT and IDLE until the next hit.
REQ-024 A pass for channel i SHALL be detected in PLAY when the registered previous value of pipe_x+PIPE_W-1 was >= BOX_X and the current value is < BOX_X.
REQ-025 On a pass, score SHALL increment by one, saturating at all-ones.
REQ-026 Passes in the same cycle SHALL add their count.
REQ-027 If a pass and an overlap occur in the same cycle, the hit wins and score is not incremented.
REQ-028 If start and ack are both high in HIT, only ack takes effect.

Reset
REQ-029 While resetn is low, the block SHALL be in IDLE with collided=0, hit_id=0, score=0, playing=0, and previous-x registers = 0.
REQ-030 Reset asserted mid-round or in HIT SHALL abort immediately, independent of CLOCK_50.

Configuration
REQ-031 With GROUND_COLLIDE_EN defined, in PLAY, box_y=0 or box_y+BOX_H-1 >= SCREEN_H-1 SHALL cause PLAY->HIT with hit_id=NUM_PIPES; a pipe overlap in the same cycle takes precedence.
REQ-032 Without GROUND_COLLIDE_EN, screen edges SHALL never cause a hit.

Structure
REQ-033 Package collision_pkg SHALL hold the FSM state enum, the hit_id width constant and the default geometry constants.
REQ-034 Per-channel overlap SHALL be a combinational sub-module, pipe_overlap, instantiated NUM_PIPES times by a generate loop.

Verification
REQ-035 The bench SHALL cover the following directed scenarios with defaults.
  Scenario 1, PLAY hit and ack: start; pipe_x0=4, pipe_y0=40, box_y=20 -> collided=1 and hit_id=0 one cycle later; ack -> IDLE with hit_id still 0.
  Scenario 2, gap boundaries: box_y=40 and box_y=70 with pipe_y0=40 -> no hit; box_y=71 -> hit.
  Scenario 3, simultaneous overlap: channels 1 and 2 at x=4 with box outside both gaps -> hit_id=1.
  Scenario 4, score and saturation: pipe_x0 steps 5,4,3 with the box inside the gap -> score 0,0,1; SCORE_W=2 with 5 passes -> score=3.
  Scenario 5, overflow: pipe_y0=100 with box_y=127 -> hit; box_y=110 -> no hit (no 7-bit wrap).
  Scenario 6, async reset: resetn low mid-HIT between clock edges -> all outputs 0 immediately; GROUND_COLLIDE_EN build with box_y=0 in PLAY -> hit_id=3.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types and default geometry for the pipe collision engine.
package collision_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2
  } state_e;

  localparam int HIT_ID_W = 4;

  localparam int DEF_NUM_PIPES = 3;
  localparam int DEF_X_W       = 9;
  localparam int DEF_Y_W       = 7;
  localparam int DEF_BOX_X     = 4;
  localparam int DEF_BOX_W     = 1;
  localparam int DEF_BOX_H     = 1;
  localparam int DEF_PIPE_W    = 1;
  localparam int DEF_GAP_H     = 30;
  localparam int DEF_SCREEN_H  = 120;
  localparam int DEF_SCORE_W   = 8;

endpackage

// File: rtl/pipe_overlap.sv
// Combinational box-versus-pipe overlap test for one pipe channel.
// Sums are widened by two bits so gap bottoms past the screen never wrap.
module pipe_overlap
  import collision_pkg::*;
#(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int BOX_X    = DEF_BOX_X,
  parameter int BOX_W    = DEF_BOX_W,
  parameter int BOX_H    = DEF_BOX_H,
  parameter int PIPE_W   = DEF_PIPE_W,
  parameter int GAP_H    = DEF_GAP_H,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic [X_W-1:0] pipe_x,
  input  logic [Y_W-1:0] pipe_y,
  input  logic [Y_W-1:0] box_y,
  output logic           overlap,
  output logic [X_W+1:0] pipe_right
);

  localparam logic [X_W+1:0] BOX_L     = (X_W+2)'(BOX_X);
  localparam logic [X_W+1:0] BOX_R     = (X_W+2)'(BOX_X + BOX_W - 1);
  localparam logic [X_W+1:0] PIPE_W_M1 = (X_W+2)'(PIPE_W - 1);
  localparam logic [Y_W+1:0] BOX_H_M1  = (Y_W+2)'(BOX_H - 1);
  localparam logic [Y_W+1:0] GAP_SPAN  = (Y_W+2)'(GAP_H);
  localparam logic [Y_W+1:0] SCR_BOT   = (Y_W+2)'(SCREEN_H - 1);

  logic [X_W+1:0] pipe_l_s;
  logic [Y_W+1:0] box_top_s;
  logic [Y_W+1:0] box_bot_s;
  logic [Y_W+1:0] gap_top_s;
  logic [Y_W+1:0] gap_raw_s;
  logic [Y_W+1:0] gap_bot_s;
  logic           x_hit_s;
  logic           in_gap_s;

  assign pipe_l_s   = {2'b00, pipe_x};
  assign pipe_right = pipe_l_s + PIPE_W_M1;
  assign box_top_s  = {2'b00, box_y};
  assign box_bot_s  = box_top_s + BOX_H_M1;
  assign gap_top_s  = {2'b00, pipe_y};
  assign gap_raw_s  = gap_top_s + GAP_SPAN;
  // A gap reaching below the last screen row is clipped to that row.
  assign gap_bot_s  = (gap_raw_s > SCR_BOT) ? SCR_BOT : gap_raw_s;

  assign x_hit_s  = (pipe_right >= BOX_L) && (pipe_l_s <= BOX_R);
  assign in_gap_s = (box_top_s >= gap_top_s) && (box_bot_s <= gap_bot_s);
  assign overlap  = x_hit_s && !in_gap_s;

endmodule

// File: rtl/pipe_collision_engine.sv
// Round FSM, scoring and hit reporting for NUM_PIPES parallel pipe channels.
// Define GROUND_COLLIDE_EN to make the screen top/bottom rows fatal.
module pipe_collision_engine
  import collision_pkg::*;
#(
  parameter int NUM_PIPES = DEF_NUM_PIPES,
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int BOX_X     = DEF_BOX_X,
  parameter int BOX_W     = DEF_BOX_W,
  parameter int BOX_H     = DEF_BOX_H,
  parameter int PIPE_W    = DEF_PIPE_W,
  parameter int GAP_H     = DEF_GAP_H,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int SCORE_W   = DEF_SCORE_W
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     ack,
  input  logic [Y_W-1:0]           box_y,
  input  logic [NUM_PIPES*X_W-1:0] pipe_x,
  input  logic [NUM_PIPES*Y_W-1:0] pipe_y,
  output logic                     collided,
  output logic [HIT_ID_W-1:0]      hit_id,
  output logic [SCORE_W-1:0]       score,
  output logic                     playing
);

  localparam logic [X_W+1:0] BOX_L = (X_W+2)'(BOX_X);

  state_e                          state_r;
  logic                            collided_r;
  logic [HIT_ID_W-1:0]             hit_id_r;
  logic [SCORE_W-1:0]              score_r;
  logic                            playing_r;
  logic [NUM_PIPES-1:0][X_W+1:0]   prev_right_r;

  logic [NUM_PIPES-1:0]            ov_s;
  logic [NUM_PIPES-1:0]            pass_s;
  logic [NUM_PIPES-1:0][X_W+1:0]   right_s;
  logic                            any_ov_s;
  logic [HIT_ID_W-1:0]             first_s;
  logic [3:0]                      pass_cnt_s;
  logic                            edge_hit_s;
  logic                            hit_s;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [3:0]         b);
    logic [SCORE_W+3:0] sum;
    sum = {4'b0000, a} + {{SCORE_W{1'b0}}, b};
    if (sum > {4'b0000, {SCORE_W{1'b1}}}) begin
      return {SCORE_W{1'b1}};
    end else begin
      return sum[SCORE_W-1:0];
    end
  endfunction

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_ch
    pipe_overlap #(
      .X_W(X_W), .Y_W(Y_W), .BOX_X(BOX_X), .BOX_W(BOX_W), .BOX_H(BOX_H),
      .PIPE_W(PIPE_W), .GAP_H(GAP_H), .SCREEN_H(SCREEN_H)
    ) u_overlap (
      .pipe_x    (pipe_x[g*X_W +: X_W]),
      .pipe_y    (pipe_y[g*Y_W +: Y_W]),
      .box_y     (box_y),
      .overlap   (ov_s[g]),
      .pipe_right(right_s[g])
    );
    // The pipe's right edge has just moved from at/after the box column to before it.
    assign pass_s[g] = (prev_right_r[g] >= BOX_L) && (right_s[g] < BOX_L);
  end

  // Lowest overlapping channel wins; NUM_PIPES stands for a screen-edge hit.
  always_comb begin
    any_ov_s   = 1'b0;
    first_s    = HIT_ID_W'(NUM_PIPES);
    pass_cnt_s = 4'd0;
    for (int i = NUM_PIPES - 1; i >= 0; i--) begin
      if (ov_s[i]) begin
        any_ov_s = 1'b1;
        first_s  = HIT_ID_W'(i);
      end else begin
        any_ov_s = any_ov_s;
      end
      pass_cnt_s = pass_cnt_s + {3'b000, pass_s[i]};
    end
  end

`ifdef GROUND_COLLIDE_EN
  localparam logic [Y_W+1:0] BOX_H_M1 = (Y_W+2)'(BOX_H - 1);
  localparam logic [Y_W+1:0] SCR_BOT  = (Y_W+2)'(SCREEN_H - 1);
  logic [Y_W+1:0] box_bot_s;
  assign box_bot_s  = {2'b00, box_y} + BOX_H_M1;
  assign edge_hit_s = (box_y == {Y_W{1'b0}}) || (box_bot_s >= SCR_BOT);
`else
  assign edge_hit_s = 1'b0;
`endif

  assign hit_s = any_ov_s || edge_hit_s;

  // Round FSM with registered status outputs and per-channel x history.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      collided_r   <= 1'b0;
      hit_id_r     <= {HIT_ID_W{1'b0}};
      score_r      <= {SCORE_W{1'b0}};
      playing_r    <= 1'b0;
      prev_right_r <= '0;
    end else begin
      prev_right_r <= right_s;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r   <= ST_PLAY;
            score_r   <= {SCORE_W{1'b0}};
            playing_r <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (hit_s) begin
            state_r    <= ST_HIT;
            collided_r <= 1'b1;
            playing_r  <= 1'b0;
            hit_id_r   <= first_s;
          end else begin
            score_r <= sat_add(score_r, pass_cnt_s);
          end
        end
        ST_HIT: begin
          if (ack) begin
            state_r    <= ST_IDLE;
            collided_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          collided_r <= 1'b0;
          playing_r  <= 1'b0;
        end
      endcase
    end
  end

  assign collided = collided_r;
  assign hit_id   = hit_id_r;
  assign score    = score_r;
  assign playing  = playing_r;

endmodule

// File: tb/tb_pipe_collision_engine.sv
// Directed bench for pipe_collision_engine: vector table plus reset and saturation sequences.
module tb_pipe_collision_engine;

  localparam logic [8:0] P = 9'd200;
`ifdef GROUND_COLLIDE_EN
  localparam bit GND_EN = 1'b1;
`else
  localparam bit GND_EN = 1'b0;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic        start, ack;
  logic [6:0]  box_y;
  logic [26:0] pipe_x;
  logic [20:0] pipe_y;
  logic        collided, playing;
  logic [3:0]  hit_id;
  logic [7:0]  score;

  logic        s_start;
  logic [6:0]  s_box_y;
  logic [8:0]  s_pipe_x;
  logic [6:0]  s_pipe_y;
  logic        s_collided, s_playing;
  logic [3:0]  s_hit_id;
  logic [1:0]  s_score;

  int checks = 0;
  int failures = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  pipe_collision_engine u_dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .ack(ack),
    .box_y(box_y), .pipe_x(pipe_x), .pipe_y(pipe_y),
    .collided(collided), .hit_id(hit_id), .score(score), .playing(playing)
  );

  pipe_collision_engine #(.NUM_PIPES(1), .SCORE_W(2)) u_sat (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(s_start), .ack(1'b0),
    .box_y(s_box_y), .pipe_x(s_pipe_x), .pipe_y(s_pipe_y),
    .collided(s_collided), .hit_id(s_hit_id), .score(s_score), .playing(s_playing)
  );

  typedef struct {
    string      name;
    logic       st, ak;
    logic [6:0] by;
    logic [8:0] px0, px1, px2;
    logic [6:0] py0, py1, py2;
    logic       ec;
    logic [3:0] eh;
    logic [7:0] es;
    logic       ep;
  } vec_t;

  vec_t vec_q[$];

  task automatic add_vec(input string n, input logic st, input logic ak, input logic [6:0] by,
                         input logic [8:0] px0, input logic [6:0] py0,
                         input logic [8:0] px1, input logic [6:0] py1,
                         input logic [8:0] px2, input logic [6:0] py2,
                         input logic ec, input logic [3:0] eh, input logic [7:0] es,
                         input logic ep);
    vec_t v;
    v.name = n; v.st = st; v.ak = ak; v.by = by;
    v.px0 = px0; v.py0 = py0; v.px1 = px1; v.py1 = py1; v.px2 = px2; v.py2 = py2;
    v.ec = ec; v.eh = eh; v.es = es; v.ep = ep;
    vec_q.push_back(v);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk_main(input string n, input logic ec, input logic [3:0] eh,
                          input logic [7:0] es, input logic ep);
    chk({n, ".collided"}, {31'd0, collided}, {31'd0, ec});
    chk({n, ".hit_id"},   {28'd0, hit_id},   {28'd0, eh});
    chk({n, ".score"},    {24'd0, score},    {24'd0, es});
    chk({n, ".playing"},  {31'd0, playing},  {31'd0, ep});
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; ack = 1'b0; box_y = 7'd50;
    pipe_x = {P, P, P}; pipe_y = 21'd0;
    s_start = 1'b0; s_box_y = 7'd50; s_pipe_x = P; s_pipe_y = 7'd40;

    //        name               st    ak    by     px0    py0     px1    py1     px2    py2     c     hid   score ply
    add_vec("s1_start_ignore", 1'b1, 1'b0, 7'd20, 9'd4, 7'd40,  P,     7'd0,   P,     7'd0,   1'b0, 4'd0, 8'd0, 1'b1);
    add_vec("s1_hit",          1'b0, 1'b0, 7'd20, 9'd4, 7'd40,  P,     7'd0,   P,     7'd0,   1'b1, 4'd0, 8'd0, 1'b0);
    add_vec("s1_ack",          1'b0, 1'b1, 7'd20, 9'd4, 7'd40,  P,     7'd0,   P,     7'd0,   1'b0, 4'd0, 8'd0, 1'b0);
    add_vec("s2_start",        1'b1, 1'b0, 7'd40, 9'd4, 7'd40,  P,     7'd0,   P,     7'd0,   1'b0, 4'd0, 8'd0, 1'b1);
    add_vec("s2_gap_top",      1'b0, 1'b0, 7'd40, 9'd4, 7'd40,  P,     7'd0,   P,     7'd0,   1'b0, 4'd0, 8'd0, 1'b1);
    add_vec("s2_gap_bot",      1'b0, 1'b0, 7'd70, 9'd4, 7'd40,  P,     7'd0,   P,     7'd0,   1'b0, 4'd0, 8'd0, 1'b1);
    add_vec("s2_below_gap",    1'b0, 1'b0, 7'd71, 9'd4, 7'd40,  P,     7'd0,   P,     7'd0,   1'b1, 4'd0, 8'd0, 1'b0);
    add_vec("s2_ack",          1'b0, 1'b1, 7'd71, 9'd4, 7'd40,  P,     7'd0,   P,     7'd0,   1'b0, 4'd0, 8'd0, 1'b0);
    add_vec("s3_start",        1'b1, 1'b0, 7'd50, P,    7'd0,   P,     7'd0,   P,     7'd0,   1'b0, 4'd0, 8'd0, 1'b1);
    add_vec("s3_dual_hit",     1'b0, 1'b0, 7'd50, P,    7'd0,   9'd4,  7'd100, 9'd4,  7'd100, 1'b1, 4'd1, 8'd0, 1'b0);
    add_vec("s3_ack",          1'b0, 1'b1, 7'd50, P,    7'd0,   P,     7'd0,   P,     7'd0,   1'b0, 4'd1, 8'd0, 1'b0);
    add_vec("s4_start",        1'b1, 1'b0, 7'd50, 9'd5, 7'd40,  P,     7'd0,   P,     7'd0,   1'b0, 4'd1, 8'd0, 1'b1);
    add_vec("s4_x4",           1'b0, 1'b0, 7'd50, 9'd4, 7'd40,  P,     7'd0,   P,     7'd0,   1'b0, 4'd1, 8'd0, 1'b1);
    add_vec("s4_x3_pass",      1'b0, 1'b0, 7'd50, 9'd3, 7'd40,  P,     7'd0,   P,     7'd0,   1'b0, 4'd1, 8'd1, 1'b1);
    add_vec("s4_x2",           1'b0, 1'b0, 7'd50, 9'd2, 7'd40,  P,     7'd0,   P,     7'd0,   1'b0, 4'd1, 8'd1, 1'b1);
    add_vec("s4_dual_arm5",    1'b0, 1'b0, 7'd50, 9'd2, 7'd40,  9'd5,  7'd40,  9'd5,  7'd40,  1'b0, 4'd1, 8'd1, 1'b1);
    add_vec("s4_dual_arm4",    1'b0, 1'b0, 7'd50, 9'd2, 7'd40,  9'd4,  7'd40,  9'd4,  7'd40,  1'b0, 4'd1, 8'd1, 1'b1);
    add_vec("s4_dual_pass",    1'b0, 1'b0, 7'd50, 9'd2, 7'd40,  9'd3,  7'd40,  9'd3,  7'd40,  1'b0, 4'd1, 8'd3, 1'b1);
    add_vec("s4_rearm",        1'b0, 1'b0, 7'd50, 9'd2, 7'd40,  9'd4,  7'd40,  9'd5,  7'd40,  1'b0, 4'd1, 8'd3, 1'b1);
    add_vec("pass_vs_hit",     1'b0, 1'b0, 7'd50, 9'd2, 7'd40,  9'd3,  7'd40,  9'd4,  7'd100, 1'b1, 4'd2, 8'd3, 1'b0);
    add_vec("hit_start_ack",   1'b1, 1'b1, 7'd50, P,    7'd0,   P,     7'd0,   P,     7'd0,   1'b0, 4'd2, 8'd3, 1'b0);
    add_vec("restart_clear",   1'b1, 1'b0, 7'd50, P,    7'd0,   P,     7'd0,   P,     7'd0,   1'b0, 4'd2, 8'd0, 1'b1);
    add_vec("play_ack_ignore", 1'b0, 1'b1, 7'd50, P,    7'd0,   P,     7'd0,   P,     7'd0,   1'b0, 4'd2, 8'd0, 1'b1);
    add_vec("s5_no_wrap",      1'b0, 1'b0, 7'd110, 9'd4, 7'd100, P,    7'd0,   P,     7'd0,   1'b0, 4'd2, 8'd0, 1'b1);
    add_vec("s5_clip_hit",     1'b0, 1'b0, 7'd127, 9'd4, 7'd100, P,    7'd0,   P,     7'd0,   1'b1, 4'd0, 8'd0, 1'b0);
    add_vec("s5_ack",          1'b0, 1'b1, 7'd50, P,    7'd0,   P,     7'd0,   P,     7'd0,   1'b0, 4'd0, 8'd0, 1'b0);
    add_vec("edge_start",      1'b1, 1'b0, 7'd50, P,    7'd0,   P,     7'd0,   P,     7'd0,   1'b0, 4'd0, 8'd0, 1'b1);
    add_vec("edge_top_row",    1'b0, 1'b0, 7'd0,  P,    7'd0,   P,     7'd0,   P,     7'd0,
            GND_EN, GND_EN ? 4'd3 : 4'd0, 8'd0, !GND_EN);
    add_vec("edge_after",      1'b0, 1'b1, 7'd50, P,    7'd0,   P,     7'd0,   P,     7'd0,
            1'b0, GND_EN ? 4'd3 : 4'd0, 8'd0, !GND_EN);

    repeat (2) step();
    chk_main("reset", 1'b0, 4'd0, 8'd0, 1'b0);
    resetn = 1'b1;

    foreach (vec_q[k]) begin
      start = vec_q[k].st;
      ack   = vec_q[k].ak;
      box_y = vec_q[k].by;
      pipe_x = {vec_q[k].px2, vec_q[k].px1, vec_q[k].px0};
      pipe_y = {vec_q[k].py2, vec_q[k].py1, vec_q[k].py0};
      step();
      chk_main(vec_q[k].name, vec_q[k].ec, vec_q[k].eh, vec_q[k].es, vec_q[k].ep);
    end

    // Saturation on a 2-bit score: each 4->3 move is one pass.
    s_start = 1'b1; s_pipe_x = 9'd4;
    step();
    chk("sat.playing", {31'd0, s_playing}, 32'd1);
    s_start = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      s_pipe_x = 9'd3;
      step();
      s_pipe_x = 9'd4;
      step();
      if (n == 2) chk("sat.score_after2", {30'd0, s_score}, 32'd2);
    end
    chk("sat.score_after5", {30'd0, s_score}, 32'd3);
    chk("sat.collided", {31'd0, s_collided}, 32'd0);

    // Asynchronous reset in the middle of HIT, between clock edges.
    start = 1'b0; ack = 1'b0; resetn = 1'b0;
    #1;
    chk_main("rst_any", 1'b0, 4'd0, 8'd0, 1'b0);
    step();
    resetn = 1'b1;
    start = 1'b1; box_y = 7'd50; pipe_x = {P, P, 9'd5}; pipe_y = {7'd0, 7'd0, 7'd40};
    step();
    start = 1'b0; pipe_x = {P, P, 9'd4};
    step();
    pipe_x = {P, P, 9'd3};
    step();
    chk_main("pre_hit_score", 1'b0, 4'd0, 8'd1, 1'b1);
    box_y = 7'd20; pipe_x = {P, 9'd4, 9'd3}; pipe_y = {7'd0, 7'd40, 7'd40};
    step();
    chk_main("pre_rst_hit", 1'b1, 4'd1, 8'd1, 1'b0);
    #3;
    resetn = 1'b0;
    #1;
    chk_main("async_rst_mid_hit", 1'b0, 4'd0, 8'd0, 1'b0);
    step();
    chk_main("rst_held", 1'b0, 4'd0, 8'd0, 1'b0);
    resetn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
